// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32 execute stage: 1-cycle ALU, multi-cycle multiply/divide
// Optional M-extension datapath is built only when EX_MULDIV_EN is defined.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int PC_STEP    = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [4:0]      op_in,
    input  logic            src_imm_in,
    input  logic [XLEN-1:0] rs1_val_in,
    input  logic [XLEN-1:0] rs2_val_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            rd_in,
    input  logic [4:0]      rd_addr_in,
    output logic            valid_out,
    output logic            rd_out,
    output logic [4:0]      rd_addr_out,
    output logic [XLEN-1:0] rd_val_out,
    output logic [XLEN-1:0] pc_out,
    output logic            illegal_out,
    output logic            stallreq_from_ex
);
    localparam int SHW = $clog2(XLEN);

    logic [XLEN-1:0] opb;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_val;
    logic            alu_illegal;
    logic            accept;
    logic            is_multi;
    logic            op_illegal;
    logic            m_done;
    logic [XLEN-1:0] m_val;
    logic            m_rd;
    logic [4:0]      m_rd_addr;
    logic [XLEN-1:0] m_pc;

    assign opb    = src_imm_in ? imm_in : rs2_val_in;
    assign shamt  = opb[SHW-1:0];
    assign accept = valid_in & ready_out & ~flush_in;

    // Single-cycle ALU result and ALU op-code legality
    always_comb begin
        alu_val     = '0;
        alu_illegal = 1'b0;
        case (op_in)
            5'd0:    alu_val = rs1_val_in + opb;
            5'd1:    alu_val = rs1_val_in - opb;
            5'd2:    alu_val = rs1_val_in << shamt;
            5'd3:    alu_val = {{(XLEN-1){1'b0}}, $signed(rs1_val_in) < $signed(opb)};
            5'd4:    alu_val = {{(XLEN-1){1'b0}}, rs1_val_in < opb};
            5'd5:    alu_val = rs1_val_in ^ opb;
            5'd6:    alu_val = rs1_val_in >> shamt;
            5'd7:    alu_val = $unsigned($signed(rs1_val_in) >>> shamt);
            5'd8:    alu_val = rs1_val_in | opb;
            5'd9:    alu_val = rs1_val_in & opb;
            5'd10:   alu_val = opb;
            5'd11:   alu_val = pc_in + opb;
            5'd12:   alu_val = pc_in + XLEN'(PC_STEP);
            default: alu_illegal = 1'b1;
        endcase
    end

`ifdef EX_MULDIV_EN
    localparam int CW = $clog2(XLEN + MUL_STAGES + 2);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t            state;
    state_t            state_next;
    logic [CW-1:0]     cnt;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic [1:0]        mop;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic              neg_q;
    logic              neg_r;
    logic              is_m;
    logic [2*XLEN-1:0] mul_a;
    logic [2*XLEN-1:0] mul_b;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   mul_val;
    logic              div_signed;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic              div_special;
    logic [XLEN-1:0]   div_special_val;
    logic [XLEN:0]     r_sh;
    logic [XLEN:0]     diff;
    logic [XLEN-1:0]   rem_next;
    logic [XLEN-1:0]   quo_next;
    logic [XLEN-1:0]   q_fin;
    logic [XLEN-1:0]   r_fin;

    assign is_m             = (op_in[4:3] == 2'b10);
    assign is_multi         = is_m;
    assign op_illegal       = alu_illegal & ~is_m;
    assign ready_out        = (state == S_IDLE);
    assign stallreq_from_ex = (state != S_IDLE);

    // mop: 00 MUL, 01 MULH (s*s), 10 MULHSU (s*u), 11 MULHU (u*u)
    assign mul_a   = {{XLEN{(mop != 2'b11) & ma[XLEN-1]}}, ma};
    assign mul_b   = {{XLEN{(mop == 2'b01) & mb[XLEN-1]}}, mb};
    assign prod    = mul_a * mul_b;
    assign mul_val = (mop == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

    // mop: bit0 = unsigned, bit1 = remainder
    assign div_signed  = ~mop[0];
    assign a_neg       = div_signed & ma[XLEN-1];
    assign b_neg       = div_signed & mb[XLEN-1];
    assign a_mag       = a_neg ? (~ma + 1'b1) : ma;
    assign b_mag       = b_neg ? (~mb + 1'b1) : mb;
    assign div_special = (mb == '0) |
                         (div_signed & (ma == {1'b1, {(XLEN-1){1'b0}}}) & (mb == '1));
    assign div_special_val = (mb == '0) ? (mop[1] ? ma : '1)
                                        : (mop[1] ? '0 : ma);

    // One restoring step: shift {rem,quo} left, subtract divisor if it fits
    assign r_sh     = {rem_q, quo_q[XLEN-1]};
    assign diff     = r_sh - {1'b0, dvs_q};
    assign rem_next = diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_next = {quo_q[XLEN-2:0], ~diff[XLEN]};
    assign q_fin    = neg_q ? (~quo_next + 1'b1) : quo_next;
    assign r_fin    = neg_r ? (~rem_next + 1'b1) : rem_next;

    // Next-state and multi-cycle completion decode; flush overrides completion
    always_comb begin
        state_next = state;
        m_done     = 1'b0;
        m_val      = '0;
        case (state)
            S_IDLE: begin
                if (accept && is_m) begin
                    state_next = op_in[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                if (cnt == CW'(MUL_STAGES - 1)) begin
                    m_done     = 1'b1;
                    m_val      = mul_val;
                    state_next = S_IDLE;
                end
            end
            S_DIV: begin
                if (cnt == '0) begin
                    if (div_special) begin
                        m_done     = 1'b1;
                        m_val      = div_special_val;
                        state_next = S_IDLE;
                    end
                end else if (cnt == CW'(XLEN)) begin
                    m_done     = 1'b1;
                    m_val      = mop[1] ? r_fin : q_fin;
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (flush_in) begin
            state_next = S_IDLE;
            m_done     = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, phase counter (cnt 0 = divider setup) and divider iteration
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt       <= '0;
            ma        <= '0;
            mb        <= '0;
            mop       <= '0;
            m_rd      <= 1'b0;
            m_rd_addr <= '0;
            m_pc      <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
        end else begin
            cnt <= (state_next == state && state != S_IDLE) ? cnt + CW'(1) : '0;
            if (accept && is_m) begin
                ma        <= rs1_val_in;
                mb        <= opb;
                mop       <= op_in[1:0];
                m_rd      <= rd_in;
                m_rd_addr <= rd_addr_in;
                m_pc      <= pc_in;
            end
            if (state == S_DIV) begin
                if (cnt == '0) begin
                    rem_q <= '0;
                    quo_q <= a_mag;
                    dvs_q <= b_mag;
                    neg_q <= a_neg ^ b_neg;
                    neg_r <= a_neg;
                end else begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                end
            end
        end
    end
`else
    assign is_multi         = 1'b0;
    assign op_illegal       = alu_illegal;
    assign ready_out        = 1'b1;
    assign stallreq_from_ex = 1'b0;
    assign m_done           = 1'b0;
    assign m_val            = '0;
    assign m_rd             = 1'b0;
    assign m_rd_addr        = '0;
    assign m_pc             = '0;
`endif

    // Result registers: ALU/illegal ops complete on accept, M ops on m_done
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_out   <= 1'b0;
            rd_out      <= 1'b0;
            rd_addr_out <= '0;
            rd_val_out  <= '0;
            pc_out      <= '0;
            illegal_out <= 1'b0;
        end else if (flush_in) begin
            valid_out <= 1'b0;
        end else if (m_done) begin
            valid_out   <= 1'b1;
            rd_out      <= m_rd;
            rd_addr_out <= m_rd_addr;
            rd_val_out  <= m_val;
            pc_out      <= m_pc;
            illegal_out <= 1'b0;
        end else if (accept && !is_multi) begin
            valid_out   <= 1'b1;
            rd_out      <= rd_in & ~op_illegal;
            rd_addr_out <= rd_addr_in;
            rd_val_out  <= op_illegal ? '0 : alu_val;
            pc_out      <= pc_in;
            illegal_out <= op_illegal;
        end else begin
            valid_out <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - scoreboard bench for ex_muldiv (ALU, M-extension when EX_MULDIV_EN)
module tb_ex_muldiv;
    localparam int MS = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_in;
    logic        valid_in;
    logic        ready_out;
    logic [4:0]  op_in;
    logic        src_imm_in;
    logic [31:0] rs1_val_in;
    logic [31:0] rs2_val_in;
    logic [31:0] imm_in;
    logic [31:0] pc_in;
    logic        rd_in;
    logic [4:0]  rd_addr_in;
    logic        valid_out;
    logic        rd_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_val_out;
    logic [31:0] pc_out;
    logic        illegal_out;
    logic        stallreq;

    typedef struct {
        logic        rd;
        logic [4:0]  addr;
        logic [31:0] val;
        logic [31:0] pc;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_val;
    logic        last_ill;
    logic        last_rd;

    ex_muldiv #(.XLEN(32), .MUL_STAGES(MS), .PC_STEP(4)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .flush_in        (flush_in),
        .valid_in        (valid_in),
        .ready_out       (ready_out),
        .op_in           (op_in),
        .src_imm_in      (src_imm_in),
        .rs1_val_in      (rs1_val_in),
        .rs2_val_in      (rs2_val_in),
        .imm_in          (imm_in),
        .pc_in           (pc_in),
        .rd_in           (rd_in),
        .rd_addr_in      (rd_addr_in),
        .valid_out       (valid_out),
        .rd_out          (rd_out),
        .rd_addr_out     (rd_addr_out),
        .rd_val_out      (rd_val_out),
        .pc_out          (pc_out),
        .illegal_out     (illegal_out),
        .stallreq_from_ex(stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] pc);
        logic [63:0] p;
        logic [31:0] r;
        logic        ill;
        r   = '0;
        ill = 1'b0;
        p   = '0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a << b[4:0];
            5'd3:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd4:  r = (a < b) ? 32'd1 : 32'd0;
            5'd5:  r = a ^ b;
            5'd6:  r = a >> b[4:0];
            5'd7:  r = $signed(a) >>> b[4:0];
            5'd8:  r = a | b;
            5'd9:  r = a & b;
            5'd10: r = b;
            5'd11: r = pc + b;
            5'd12: r = pc + 32'd4;
`ifdef EX_MULDIV_EN
            5'd16: r = a * b;
            5'd17: begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            5'd18: begin p = {{32{a[31]}}, a} * {32'd0, b}; r = p[63:32]; end
            5'd19: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            5'd20: begin
                if (b == 0) r = '1;
                else if (a == 32'h8000_0000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            5'd21: r = (b == 0) ? '1 : a / b;
            5'd22: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == '1) r = '0;
                else r = $signed(a) % $signed(b);
            end
            5'd23: r = (b == 0) ? a : a % b;
`endif
            default: ill = 1'b1;
        endcase
        return {ill, ill ? 32'd0 : r};
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef EX_MULDIV_EN
        if (op >= 5'd16 && op <= 5'd19) return MS;
        if (op >= 5'd20 && op <= 5'd23) begin
            if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == '1)) return 1;
            return 33;
        end
`endif
        return 0;
    endfunction

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic use_imm, input logic push);
        logic [32:0] m;
        exp_t        e;
        op_in      = op;
        rs1_val_in = a;
        src_imm_in = use_imm;
        if (use_imm) begin
            imm_in     = b;
            rs2_val_in = $urandom;
        end else begin
            rs2_val_in = b;
            imm_in     = $urandom;
        end
        pc_in      = $urandom & 32'hFFFF_FFFC;
        rd_in      = 1'($urandom_range(0, 1));
        rd_addr_in = 5'($urandom_range(0, 31));
        valid_in   = 1'b1;
        if (push) begin
            m      = model(op, a, b, pc_in);
            e.ill  = m[32];
            e.val  = m[31:0];
            e.rd   = rd_in & ~m[32];
            e.addr = rd_addr_in;
            e.pc   = pc_in;
            sb.push_back(e);
        end
    endtask

    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic use_imm);
        int lat;
        int stalls;
        int rdy_low;
        bit seen;
        @(negedge clk);
        drive(op, a, b, use_imm, 1'b1);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        lat = 0; stalls = 0; rdy_low = 0; seen = 1'b0;
        while (!seen && lat < 100) begin
            @(negedge clk);
            if (valid_out) begin
                seen     = 1'b1;
                last_val = rd_val_out;
                last_ill = illegal_out;
                last_rd  = rd_out;
            end else begin
                if (stallreq) stalls++;
                if (!ready_out) rdy_low++;
                @(posedge clk);
                lat++;
            end
        end
        check({tag, "_seen"}, 64'(seen), 64'd1);
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, a, b)));
        check({tag, "_stall"}, 64'(stalls), 64'(exp_lat(op, a, b)));
        check({tag, "_rdy_low"}, 64'(rdy_low), 64'(exp_lat(op, a, b)));
    endtask

    // Scoreboard: every result strobe must match the oldest pending expectation
    always @(negedge clk) begin
        if (valid_out) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("sb_val", 64'(rd_val_out), 64'(mon_e.val));
                check("sb_rd", 64'(rd_out), 64'(mon_e.rd));
                check("sb_addr", 64'(rd_addr_out), 64'(mon_e.addr));
                check("sb_pc", 64'(pc_out), 64'(mon_e.pc));
                check("sb_ill", 64'(illegal_out), 64'(mon_e.ill));
            end
        end
    end

    task automatic quiet_window(input string tag, input int cycles);
        int n;
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_out) n++;
        end
        check(tag, 64'(n), 64'd0);
    endtask

    initial begin
        rst = 1'b1; flush_in = 1'b0; valid_in = 1'b0; op_in = '0; src_imm_in = 1'b0;
        rs1_val_in = '0; rs2_val_in = '0; imm_in = '0; pc_in = '0; rd_in = 1'b0; rd_addr_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_rd", 64'(rd_out), 64'd0);
        check("rst_addr", 64'(rd_addr_out), 64'd0);
        check("rst_val", 64'(rd_val_out), 64'd0);
        check("rst_pc", 64'(pc_out), 64'd0);
        check("rst_ill", 64'(illegal_out), 64'd0);
        check("rst_stall", 64'(stallreq), 64'd0);
        rst = 1'b0;

        run_op("add", 5'd0, 32'd5, 32'd7, 1'b0);
        check("add_const", 64'(last_val), 64'd12);
        run_op("sra", 5'd7, 32'h8000_0000, 32'd4, 1'b1);
        check("sra_const", 64'(last_val), 64'hF800_0000);
        run_op("sub", 5'd1, 32'd3, 32'd10, 1'b0);
        run_op("sll", 5'd2, 32'h0000_00F1, 32'h0000_0024, 1'b1);
        run_op("slt", 5'd3, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("sltu", 5'd4, 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_op("srl", 5'd6, 32'h8000_0000, 32'd31, 1'b0);
        run_op("lui", 5'd10, 32'd0, 32'hABCD_E000, 1'b1);
        run_op("auipc", 5'd11, 32'd0, 32'h0000_1000, 1'b1);
        run_op("link", 5'd12, 32'd0, 32'd0, 1'b0);
        run_op("ill13", 5'd13, 32'd1, 32'd2, 1'b0);
        run_op("ill31", 5'd31, 32'd1, 32'd2, 1'b0);

        run_op("mulhu", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op("div", 5'd20, 32'hFFFF_FFF9, 32'd2, 1'b0);
`ifdef EX_MULDIV_EN
        check("div_const", 64'(last_val), 64'hFFFF_FFFD);
`endif
        run_op("rem", 5'd22, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op("divu0", 5'd21, 32'd100, 32'd0, 1'b0);
        run_op("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op("mul", 5'd16, 32'd3, 32'd4, 1'b0);
`ifdef EX_MULDIV_EN
        check("mul_const", 64'(last_val), 64'd12);
`else
        check("mul_ill", 64'(last_ill), 64'd1);
        check("mul_rd", 64'(last_rd), 64'd0);
`endif
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            run_op("rand_m", 5'(16 + (i % 8)), a, b, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            check("b2b_ready", 64'(ready_out), 64'd1);
            drive(5'($urandom_range(0, 14)), $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1);
        end
        @(negedge clk);
        valid_in = 1'b0;
        repeat (3) @(negedge clk);

        @(negedge clk);
        drive(5'd0, 32'd1, 32'd2, 1'b0, 1'b0);
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        flush_in = 1'b0;
        @(negedge clk);
        check("flush_same_valid", 64'(valid_out), 64'd0);
        check("flush_same_ready", 64'(ready_out), 64'd1);

`ifdef EX_MULDIV_EN
        @(negedge clk);
        drive(5'd21, 32'd1000, 32'd3, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("div_busy_at_10", 64'(stallreq), 64'd1);
        flush_in = 1'b1;
        @(posedge clk);
        #1;
        flush_in = 1'b0;
        @(negedge clk);
        check("flush_div_valid", 64'(valid_out), 64'd0);
        check("flush_div_ready", 64'(ready_out), 64'd1);
        quiet_window("flush_div_quiet", 40);
`endif

        run_op("pre_rst", 5'd0, 32'd5, 32'd7, 1'b0);
`ifdef EX_MULDIV_EN
        @(negedge clk);
        drive(5'd20, 32'd12345, 32'd7, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (9) @(posedge clk);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", 64'(valid_out), 64'd0);
        check("mid_rst_rd", 64'(rd_out), 64'd0);
        check("mid_rst_addr", 64'(rd_addr_out), 64'd0);
        check("mid_rst_val", 64'(rd_val_out), 64'd0);
        check("mid_rst_pc", 64'(pc_out), 64'd0);
        check("mid_rst_ill", 64'(illegal_out), 64'd0);
        check("mid_rst_stall", 64'(stallreq), 64'd0);
        check("mid_rst_ready", 64'(ready_out), 64'd1);
        quiet_window("mid_rst_quiet", 40);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
Registered, parametrised execute stage for the RV32 core; it sits between the ID/EX and EX/MEM pipeline registers.
- Executes integer ALU ops in 1 cycle and M-extension ops in multiple cycles.
- Multiply latency is a fixed pipeline depth; divide/remainder uses an iterative radix-2 divider.
- Raises stallreq_from_ex to freeze upstream stages while a multi-cycle op is in flight.

Parameters:
XLEN, 32, datapath width (operands, immediate, result, pc)
MUL_STAGES, 2, multiply latency in cycles (>=1)
PC_STEP, 4, link-address increment

Ports:
clk_in  input  1  clock, all state updates on rising edge
rst_in  input  1  synchronous reset, active-high
flush_in  input  1  kill in-flight op and the current input (branch mispredict)
valid_in  input  1  op presented this cycle
ready_out  output  1  high when an op can be accepted this cycle
op_in  input  5  op code (see Behaviour)
src_imm_in  input  1  1: operand b = imm_in, 0: operand b = rs2_val_in
rs1_val_in  input  XLEN  operand a
rs2_val_in  input  XLEN  register operand b
imm_in  input  XLEN  sign-extended immediate
pc_in  input  XLEN  instruction pc
rd_in  input  1  writeback enable
rd_addr_in  input  5  destination register
valid_out  output  1  one-cycle result strobe
rd_out  output  1  writeback enable, qualified by valid_out
rd_addr_out  output  5  destination register
rd_val_out  output  XLEN  result
pc_out  output  XLEN  pc of completing op
illegal_out  output  1  op code not supported; pulses with valid_out
stallreq_from_ex  output  1  equals busy (multi-cycle op in flight)

Behaviour:
- Reset (rst_in=1 at edge): all outputs 0, FSM to IDLE, divider/multiplier pipeline cleared. Reset mid-operation aborts the op; no valid_out is produced for it.
- Op codes:
  - ALU: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 LUI (b), 11 AUIPC (pc+b), 12 LINK (pc+PC_STEP).
  - M-extension: 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU.
  - Any other code: illegal, rd_out=0, rd_val_out=0.
- Shifts use b[$clog2(XLEN)-1:0]. SLT/SLTU return 1 or 0, zero-extended. All arithmetic is mod 2^XLEN.
- Accept = valid_in & ready_out & ~flush_in. ready_out = ~busy.
- FSM states:
  - IDLE: accepted ALU/illegal op -> result registered, valid_out=1 next cycle, stay IDLE. Accepted MUL* -> MUL. Accepted DIV* -> DIV.
  - MUL: busy for MUL_STAGES cycles. valid_out fires exactly MUL_STAGES cycles after accept, with FSM returning to IDLE on that same edge. MULH* return bits [2*XLEN-1:XLEN] of the signed/signed, signed/unsigned or unsigned/unsigned product.
  - DIV: restoring divide on magnitudes, one quotient bit per cycle. valid_out fires XLEN+1 cycles after accept: 1 setup cycle plus XLEN iterations. Result sign fixed in the final cycle.
  - DIV special cases resolve in the setup cycle, so valid_out fires 1 cycle after accept:
    - divisor 0: quotient all-ones, remainder = dividend.
    - signed overflow (dividend -2^(XLEN-1), divisor -1): quotient = dividend, remainder 0.
- In MUL/DIV, valid_in is ignored and stallreq_from_ex=1. The upstream stage holds its op.
- flush_in=1: FSM to IDLE, no valid_out next cycle, input not accepted. Flush wins over a same-cycle valid_in and over a same-cycle completion.
- Result registers (rd_*, pc_out, illegal_out) hold their last value between strobes. Consumers qualify with valid_out.
- Back-to-back ALU ops: one result per cycle.

Optional Feature:
EX_MULDIV_EN
- Defined: M-extension ops are executed as described above.
- Undefined: multiplier and divider are not synthesised. Op codes 16-23 are treated as illegal: 1-cycle latency, illegal_out=1, rd_out=0. stallreq_from_ex is tied 0 and ready_out tied 1.

Test Plan:
- Reset then ADD rs1=5, rs2=7, src_imm=0 -> next cycle valid_out=1, rd_val_out=12. SRA rs1=0x80000000, imm=4, src_imm=1 -> 0xF8000000.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> valid_out exactly MUL_STAGES cycles later, rd_val_out=0xFFFFFFFE, stallreq_from_ex high for MUL_STAGES cycles.
- DIV -7/2 -> 33 cycles later quotient 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; ready_out=0 throughout.
- DIVU 100/0 -> 1 cycle, 0xFFFFFFFF; REM 0x80000000/-1 -> 1 cycle, 0; DIV 0x80000000/-1 -> 0x80000000.
- Start DIVU, assert flush_in at cycle 10 -> no valid_out, ready_out=1 next cycle. Repeat with rst_in mid-divide -> all outputs 0.
- Without EX_MULDIV_EN: MUL 3*4 -> 1 cycle, illegal_out=1, rd_out=0, stallreq_from_ex stays 0.
